// File: rtl/hub75_fb_arbiter.sv
// Round-robin framebuffer access arbiter with buffer rotation. The grant is registered one cycle after the request, and it holds until release (or timeout).
// Rotations wait for an IDLE cycle. Optional grant timeout when HUB75_FB_ARB_TIMEOUT_EN is defined.
module hub75_fb_arbiter #(
  parameter int N_PORTS = 3,
  parameter int N_BUFS  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] rel,
  output logic [N_PORTS-1:0] gnt,
  input  logic               frame_swap,
  output logic               swap_pend,
  output logic               swap_done,
  output logic [1:0]         rd_buf,
  output logic [1:0]         wr_buf,
  output logic               timeout_err
);

  localparam int PW = $clog2(N_PORTS);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      ptr, ptr_nxt;
  logic [PW-1:0]      winner, idx;
  logic [N_PORTS-1:0] gnt_nxt;
  logic               any_req, rel_hit, expire, err_nxt, apply;
  logic [1:0]         spare;
  int                 cand;

  assign rel_hit = |(rel & gnt);
  assign apply   = (state == IDLE) && swap_pend;

  // Lowest offset from ptr wins, so scan from the far end down.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    cand    = 0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= N_PORTS) cand = cand - N_PORTS;
      idx = PW'(cand);
      if (req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

`ifdef HUB75_FB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (state == GRANT) cnt <= cnt + 1'b1;
    else                     cnt <= '0;
  end

  assign expire = (state == GRANT) && (cnt == CW'(TIMEOUT - 1));
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   if (rel_hit || expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A release on the expiry cycle takes the normal path, so no error pulse.
  always_comb begin
    gnt_nxt = gnt;
    ptr_nxt = ptr;
    err_nxt = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (any_req) begin
          gnt_nxt[winner] = 1'b1;
          ptr_nxt = (winner == PW'(N_PORTS - 1)) ? '0 : winner + 1'b1;
        end
      end
      GRANT: begin
        if (rel_hit) begin
          gnt_nxt = '0;
        end else if (expire) begin
          gnt_nxt = '0;
          err_nxt = 1'b1;
        end
      end
      default: gnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= '0;
      ptr         <= '0;
      timeout_err <= 1'b0;
      swap_pend   <= 1'b0;
      swap_done   <= 1'b0;
      rd_buf      <= 2'd0;
      wr_buf      <= 2'd1;
      spare       <= 2'd2;
    end else begin
      gnt         <= gnt_nxt;
      ptr         <= ptr_nxt;
      timeout_err <= err_nxt;
      swap_pend   <= apply ? 1'b0 : (swap_pend | frame_swap);
      swap_done   <= apply;
      if (apply) begin
        if (N_BUFS == 2) begin
          rd_buf <= wr_buf;
          wr_buf <= rd_buf;
        end else begin
          rd_buf <= wr_buf;
          wr_buf <= spare;
          spare  <= rd_buf;
        end
      end
    end
  end

endmodule

// File: tb/tb_hub75_fb_arbiter.sv
// Directed bench for hub75_fb_arbiter: a 2-buffer and a 3-buffer instance share all inputs.
module tb_hub75_fb_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = '0;
  logic [2:0] rel = '0;
  logic       frame_swap = 1'b0;

  logic [2:0] gnt, gnt3;
  logic       swap_pend, swap_done, timeout_err;
  logic       swap_pend3, swap_done3, timeout_err3;
  logic [1:0] rd_buf, wr_buf, rd_buf3, wr_buf3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hub75_fb_arbiter #(.N_PORTS(3), .N_BUFS(2), .TIMEOUT(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .gnt(gnt),
    .frame_swap(frame_swap), .swap_pend(swap_pend), .swap_done(swap_done),
    .rd_buf(rd_buf), .wr_buf(wr_buf), .timeout_err(timeout_err)
  );

  hub75_fb_arbiter #(.N_PORTS(3), .N_BUFS(3), .TIMEOUT(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .gnt(gnt3),
    .frame_swap(frame_swap), .swap_pend(swap_pend3), .swap_done(swap_done3),
    .rd_buf(rd_buf3), .wr_buf(wr_buf3), .timeout_err(timeout_err3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [1:0] rd2_exp [3] = '{2'd1, 2'd0, 2'd1};
  logic [1:0] wr2_exp [3] = '{2'd0, 2'd1, 2'd0};
  logic [1:0] rd3_exp [3] = '{2'd1, 2'd2, 2'd0};
  logic [1:0] wr3_exp [3] = '{2'd2, 2'd0, 2'd1};

  initial begin
    #12;
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_pend", swap_pend, 1'b0);
    chk("rst_done", swap_done, 1'b0);
    chk("rst_err", timeout_err, 1'b0);
    chk("rst_rd", rd_buf, 2'd0);
    chk("rst_wr", wr_buf, 2'd1);
    chk("rst_rd3", rd_buf3, 2'd0);
    chk("rst_wr3", wr_buf3, 2'd1);
    rst_n = 1'b1;

    // Round robin with one idle cycle between grants.
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_gnt", gnt, rr_exp[i]);
      rel = rr_exp[i];
      tick();
      rel = '0;
      chk("rr_idle", gnt, 3'b000);
    end
    req = '0;
    rel = 3'b111;
    tick();
    rel = '0;
    chk("idle_rel_ignored", gnt, 3'b000);

    // Foreign rel and dropped req do not revoke (ptr=1, only port 0 requests).
    req = 3'b001;
    tick();
    chk("wrap_gnt", gnt, 3'b001);
    req = '0;
    rel = 3'b010;
    tick();
    chk("hold_gnt", gnt, 3'b001);
    rel = 3'b001;
    tick();
    rel = '0;
    chk("hold_rel", gnt, 3'b000);

    // Three rotations in IDLE.
    for (int i = 0; i < 3; i++) begin
      frame_swap = 1'b1;
      tick();
      frame_swap = 1'b0;
      chk("sw_pend", swap_pend, 1'b1);
      chk("sw_done0", swap_done, 1'b0);
      tick();
      chk("sw_pend_clr", swap_pend, 1'b0);
      chk("sw_done", swap_done, 1'b1);
      chk("sw_rd2", rd_buf, rd2_exp[i]);
      chk("sw_wr2", wr_buf, wr2_exp[i]);
      chk("sw_rd3", rd_buf3, rd3_exp[i]);
      chk("sw_wr3", wr_buf3, wr3_exp[i]);
      tick();
      chk("sw_done_end", swap_done, 1'b0);
    end

    // Rotation deferred during a grant, repeated pulses merged.
    req = 3'b010;
    tick();
    chk("gr_gnt", gnt, 3'b010);
    for (int i = 0; i < 3; i++) begin
      frame_swap = 1'b1;
      tick();
      frame_swap = 1'b0;
      tick();
      chk("gr_pend", swap_pend, 1'b1);
      chk("gr_done", swap_done, 1'b0);
      chk("gr_rd", rd_buf, 2'd1);
      chk("gr_wr", wr_buf, 2'd0);
    end
    req = '0;
    rel = 3'b010;
    tick();
    rel = '0;
    chk("gr_rel_gnt", gnt, 3'b000);
    chk("gr_rel_pend", swap_pend, 1'b1);
    chk("gr_rel_done", swap_done, 1'b0);
    tick();
    chk("gr_ap_done", swap_done, 1'b1);
    chk("gr_ap_pend", swap_pend, 1'b0);
    chk("gr_ap_rd", rd_buf, 2'd0);
    chk("gr_ap_wr", wr_buf, 2'd1);
    chk("gr_ap_rd3", rd_buf3, 2'd1);
    chk("gr_ap_wr3", wr_buf3, 2'd2);
    tick();
    chk("gr_once", swap_done, 1'b0);

    // Rotation and grant on the same edge.
    frame_swap = 1'b1;
    tick();
    frame_swap = 1'b0;
    req = 3'b100;
    tick();
    chk("co_gnt", gnt, 3'b100);
    chk("co_done", swap_done, 1'b1);
    chk("co_rd", rd_buf, 2'd1);
    chk("co_rd3", rd_buf3, 2'd2);
    chk("co_wr3", wr_buf3, 2'd0);
    req = '0;
    rel = 3'b100;
    tick();
    rel = '0;
    chk("co_rel", gnt, 3'b000);

`ifdef HUB75_FB_ARB_TIMEOUT_EN
    req = 3'b011;
    tick();
    chk("to_gnt", gnt, 3'b001);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_hold", gnt, 3'b001);
      chk("to_err0", timeout_err, 1'b0);
    end
    tick();
    chk("to_drop", gnt, 3'b000);
    chk("to_err", timeout_err, 1'b1);
    tick();
    chk("to_err_end", timeout_err, 1'b0);
    chk("to_next", gnt, 3'b010);
    req = '0;
    rel = 3'b010;
    tick();
    rel = '0;
    chk("to_rel", gnt, 3'b000);
`else
    req = 3'b001;
    tick();
    chk("nt_gnt", gnt, 3'b001);
    req = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("nt_hold", gnt, 3'b001);
      chk("nt_err", timeout_err, 1'b0);
    end
    rel = 3'b001;
    tick();
    rel = '0;
    chk("nt_rel", gnt, 3'b000);
`endif

    // Asynchronous reset mid-grant with a rotation pending.
    req = 3'b111;
    tick();
    chk("ar_gnt", {31'd0, |gnt}, 32'd1);
    frame_swap = 1'b1;
    tick();
    frame_swap = 1'b0;
    chk("ar_pend", swap_pend, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt0", gnt, 3'b000);
    chk("ar_pend0", swap_pend, 1'b0);
    chk("ar_rd", rd_buf, 2'd0);
    chk("ar_wr", wr_buf, 2'd1);
    chk("ar_rd3", rd_buf3, 2'd0);
    chk("ar_wr3", wr_buf3, 2'd1);
    req = '0;
    #1 rst_n = 1'b1;
    tick();
    chk("ar_done_a", swap_done, 1'b0);
    tick();
    chk("ar_done_b", swap_done, 1'b0);
    chk("ar_pend_b", swap_pend, 1'b0);
    chk("ar_rd_b", rd_buf, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hub75_fb_arbiter.md
HUB75_FB_ARBITER -- requirements
Module: hub75_fb_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 3, number of framebuffer access requesters (2..8).
REQ-002 SHALL have parameter N_BUFS, default 2, number of frame buffers (2 or 3 only).
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum grant hold in cycles (>=2).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port req  in  N_PORTS  per-port access request, level.
REQ-007 SHALL have port rel  in  N_PORTS  per-port release, one-cycle pulse.
REQ-008 SHALL have port gnt  out  N_PORTS  per-port grant, registered, one-hot or zero.
REQ-009 SHALL have port frame_swap  in  1  buffer rotation request, one-cycle pulse.
REQ-010 SHALL have port swap_pend  out  1  rotation requested, not yet applied.
REQ-011 SHALL have port swap_done  out  1  one-cycle pulse on the cycle the rotation is applied.
REQ-012 SHALL have port rd_buf  out  2  buffer index for display readout.
REQ-013 SHALL have port wr_buf  out  2  buffer index for write-in.
REQ-014 SHALL have port timeout_err  out  1  one-cycle pulse on forced grant revocation.

Function
REQ-015 SHALL run a two-state FSM: IDLE (gnt all zero) and GRANT (exactly one gnt bit high).
REQ-016 In IDLE with any req bit high, SHALL assert gnt for the winning port on the next edge and enter GRANT.
REQ-017 Winner SHALL be chosen round-robin: first requesting port at or after pointer ptr, wrapping N_PORTS-1 -> 0.
REQ-018 On each grant, ptr SHALL become (winner+1) mod N_PORTS.
REQ-019 In GRANT, gnt SHALL hold until rel of the granted port; gnt SHALL drop on the next edge and the FSM SHALL return to IDLE.
REQ-020 After a release, at least one IDLE cycle with gnt all zero SHALL occur before the next grant.
REQ-021 rel bits of non-granted ports, and all rel bits in IDLE, SHALL be ignored.
REQ-022 req deassertion during GRANT SHALL NOT revoke the grant.
REQ-023 frame_swap SHALL set swap_pend on the next edge; further frame_swap pulses while pending SHALL merge (no queueing).
REQ-024 A pending rotation SHALL be applied only in an IDLE cycle; when applied, swap_pend SHALL clear and swap_done SHALL pulse for one cycle.
REQ-025 frame_swap arriving in IDLE SHALL be applied on the following IDLE cycle, or once the FSM returns to IDLE if a grant was issued meanwhile.
REQ-026 If a rotation and a grant decision occur in the same IDLE cycle, both SHALL take effect on the same edge; the granted port sees post-rotation rd_buf/wr_buf.
REQ-027 N_BUFS=2: rotation SHALL swap rd_buf and wr_buf.
REQ-028 N_BUFS=3: with spare index S internal, rotation SHALL set rd_buf<=wr_buf, wr_buf<=S, S<=rd_buf.
REQ-029 rd_buf, wr_buf (and S) SHALL always be pairwise distinct and < N_BUFS.

Reset
REQ-030 On rst_n low, asynchronously: gnt=0, FSM=IDLE, ptr=0, swap_pend=0, swap_done=0, timeout_err=0, rd_buf=0, wr_buf=1, S=2.
REQ-031 Reset mid-grant or with a rotation pending SHALL discard both; no swap_done SHALL be issued for the discarded rotation.

Configuration
REQ-032 Macro HUB75_FB_ARB_TIMEOUT_EN defined: a counter SHALL count GRANT cycles; if the granted port has not released after TIMEOUT cycles, gnt SHALL drop, FSM SHALL go IDLE, timeout_err SHALL pulse once, and ptr SHALL advance past that port.
REQ-033 A rel on the same edge as timeout expiry SHALL be treated as a normal release (no timeout_err).
REQ-034 Macro undefined: no counter SHALL be built, grants SHALL be unbounded, and timeout_err SHALL be constant 0.

Verification
REQ-035 After reset, req=3'b111 -> gnt=001 next cycle; release sequence -> grants 001, 010, 100, 001, with one IDLE cycle between each.
REQ-036 N_BUFS=2, frame_swap in IDLE -> swap_pend=1, then swap_done pulse, rd_buf=1, wr_buf=0.
REQ-037 N_BUFS=3, three frame_swap pulses each completed -> (rd,wr) = (1,2), (2,0), (0,1).
REQ-038 gnt=010 held, frame_swap plus two more pulses -> swap_pend=1 and buffers unchanged until rel; exactly one swap_done, on the first IDLE cycle.
REQ-039 HUB75_FB_ARB_TIMEOUT_EN, TIMEOUT=8, port 0 granted and never releasing -> gnt=0 after 8 GRANT cycles, one timeout_err pulse, next grant to port 1 if requesting.
REQ-040 rst_n pulsed low mid-grant with swap_pend=1 -> gnt=0, swap_pend=0, rd_buf=0, wr_buf=1 immediately; no swap_done.
